nmea_sentence_tx: RTL and testbench
===================================

NMEA_SENTENCE_TX -- requirements
Module: nmea_sentence_tx

Interface
REQ-001 SHALL have parameter TALKER, default "GP", two ASCII talker-ID characters emitted after '$'.
REQ-002 SHALL have parameter SENT_ID, default "GGA", three ASCII sentence-type characters emitted after TALKER.
REQ-003 SHALL have port CLK  in  1  single clock; all logic on posedge CLK.
REQ-004 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  in  1  request to emit one sentence; sampled only when idle.
REQ-006 SHALL have port time_bcd  in  24  hhmmss as six BCD nibbles, MSB nibble first.
REQ-007 SHALL have port fix  in  1  fix flag; 1 -> '1', 0 -> '0'.
REQ-008 SHALL have port TxD_data_out  out  8  ASCII byte toward the UART transmitter.
REQ-009 SHALL have port TxD_data_valid  out  1  TxD_data_out holds a byte.
REQ-010 SHALL have port TxD_data_ready  in  1  UART accepts byte; transfer = valid & ready in the same cycle.
REQ-011 SHALL have port busy  out  1  high from the cycle after start acceptance until the LF transfer.
REQ-012 SHALL have port done  out  1  one-cycle pulse in the cycle after the LF transfer.

Function
REQ-013 SHALL emit exactly 20 bytes: '$', TALKER(2), SENT_ID(3), ',', 6 time digits, ',', fix char, '*', checksum hi, checksum lo, CR(0x0D), LF(0x0A).
REQ-014 SHALL latch time_bcd and fix on start acceptance; later input changes do not affect the sentence in flight.
REQ-015 SHALL accept start only in IDLE; start while busy is ignored, with no queueing.
REQ-016 SHALL assert TxD_data_valid carrying '$' in the cycle after start acceptance (latency 1).
REQ-017 SHALL hold TxD_data_out stable and TxD_data_valid high while TxD_data_ready is low.
REQ-018 SHALL present the next byte in the cycle after each transfer; back-to-back transfers are allowed with ready held high, giving 20 bytes in 20 cycles.
REQ-019 SHALL encode each BCD nibble as 0x30+n; any nibble >9 SHALL be emitted as '0' (0x30).
REQ-020 SHALL compute the checksum as the 8-bit XOR of every emitted byte strictly between '$' and '*'.
REQ-021 SHALL emit the checksum as two uppercase hex ASCII characters ('0'-'9', 'A'-'F'), high nibble first.
REQ-022 SHALL use FSM states IDLE -> HDR (TALKER, SENT_ID, ',') -> TIME -> SEP -> FIX -> STAR -> CK_HI -> CK_LO -> CR -> LF -> IDLE; each state advances only on a transfer.
REQ-023 SHALL use a 3-bit index counter within HDR/TIME, cleared on each state entry.
REQ-024 SHALL accept start in the same cycle done is high, since the FSM is already in IDLE.

Reset
REQ-025 SHALL, while RST is high, force state IDLE, TxD_data_valid=0, TxD_data_out=0x00, busy=0, done=0, checksum=0x00, index=0.
REQ-026 SHALL abort a sentence in flight on RST with no trailing bytes; valid SHALL be low in the cycle after RST is sampled.
REQ-027 SHALL have RST take priority over start in the same cycle.

Structure
REQ-028 SHALL place the ASCII constants ('$', ',', '*', CR, LF, '0'), the sentence length 20 and the FSM state encodings in shared package nmea_pkg.
REQ-029 SHALL instantiate one sub-module, nmea_hex_ascii (4-bit nibble -> 8-bit uppercase hex ASCII), twice for CK_HI and CK_LO.

Verification
REQ-030 SHALL cover: time_bcd=0x123519, fix=1, ready held 1 -> "$GPGGA,123519,1*6A\r\n" in 20 consecutive cycles, then a done pulse.
REQ-031 SHALL cover: time_bcd=0x123519, fix=0 -> checksum chars "6B"; time_bcd=0x000000, fix=0 -> "66".
REQ-032 SHALL cover: ready toggled pseudo-randomly -> identical byte stream, with data held stable during every stall.
REQ-033 SHALL cover: start pulsed at byte 5, with time_bcd changed mid-sentence -> no restart, and the original digits emitted.
REQ-034 SHALL cover: RST asserted after byte 9 -> valid=0 and busy=0 next cycle; a new start yields a full sentence beginning with '$'.
REQ-035 SHALL cover: time_bcd=0x1A3519, fix=1 -> digits "103519", checksum computed over the emitted '0'.

Source files
------------

// File: rtl/nmea_pkg.sv
// Shared constants, state encoding and a BCD helper for the NMEA sentence
// transmitter. No ports; imported by nmea_sentence_tx and nmea_hex_ascii.
package nmea_pkg;

  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_COMMA  = 8'h2C;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_CR     = 8'h0D;
  localparam logic [7:0] CH_LF     = 8'h0A;
  localparam logic [7:0] CH_ZERO   = 8'h30;

  // Bytes per sentence: '$' + 5 id chars + ',' + 6 digits + ',' + fix + '*'
  // + 2 checksum chars + CR + LF.
  localparam int SENT_LEN = 20;

  // Last index values inside the multi-byte states. HDR carries '$', the
  // talker/sentence id and the trailing comma (7 bytes); TIME carries 6 digits.
  localparam logic [2:0] HDR_LAST  = 3'd6;
  localparam logic [2:0] TIME_LAST = 3'd5;

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR,
    S_TIME,
    S_SEP,
    S_FIX,
    S_STAR,
    S_CK_HI,
    S_CK_LO,
    S_CR,
    S_LF
  } state_t;

  // BCD nibble to ASCII digit; non-decimal nibbles are sent as '0'.
  function automatic logic [7:0] bcd_ascii(input logic [3:0] n);
    return (n > 4'd9) ? CH_ZERO : (CH_ZERO | {4'h0, n});
  endfunction

endpackage

// File: rtl/nmea_hex_ascii.sv
// Converts a 4-bit nibble to its uppercase hexadecimal ASCII character.
// Ports: nibble (in, 4) value 0..15; ascii (out, 8) '0'-'9' or 'A'-'F'.
module nmea_hex_ascii
  import nmea_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  // 'A' (0x41) is 0x37 + 10.
  assign ascii = (nibble < 4'd10) ? (CH_ZERO | {4'h0, nibble})
                                  : (8'h37 + {4'h0, nibble});

endmodule

// File: rtl/nmea_sentence_tx.sv
// Emits one NMEA sentence "$<TALKER><SENT_ID>,hhmmss,f*CC\r\n" as a stream of
// ASCII bytes over a valid/ready handshake toward a UART transmitter.
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   start           request one sentence (honoured only when idle)
//   time_bcd[23:0]  hhmmss as BCD nibbles, latched on start acceptance
//   fix             fix flag, latched on start acceptance
//   TxD_data_out    byte presented to the UART
//   TxD_data_valid  TxD_data_out holds a byte
//   TxD_data_ready  UART takes the byte this cycle
//   busy            sentence in flight
//   done            one-cycle pulse after the LF byte is taken
module nmea_sentence_tx
  import nmea_pkg::*;
#(
  parameter logic [15:0] TALKER  = "GP",
  parameter logic [23:0] SENT_ID = "GGA"
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [23:0] time_bcd,
  input  logic        fix,
  output logic [7:0]  TxD_data_out,
  output logic        TxD_data_valid,
  input  logic        TxD_data_ready,
  output logic        busy,
  output logic        done
);

  state_t      state, state_n;
  logic [2:0]  idx, idx_n;
  logic [7:0]  csum, csum_n;
  logic [23:0] time_q, time_n;
  logic        fix_q, fix_n;
  logic        done_q, done_n;
  logic [7:0]  tx_byte, hdr_byte, ck_hi, ck_lo;
  logic [3:0]  nib;
  logic        xfer, in_sum;

  nmea_hex_ascii u_hex_hi (.nibble(csum[7:4]), .ascii(ck_hi));
  nmea_hex_ascii u_hex_lo (.nibble(csum[3:0]), .ascii(ck_lo));

  // Reset masks the outputs immediately so nothing leaks out while RST is high.
  assign TxD_data_valid = (state != S_IDLE) & ~RST;
  assign TxD_data_out   = RST ? 8'h00 : tx_byte;
  assign busy           = TxD_data_valid;
  assign done           = done_q & ~RST;
  assign xfer           = TxD_data_valid & TxD_data_ready;

  always_comb begin
    hdr_byte = CH_COMMA;
    case (idx)
      3'd0:    hdr_byte = CH_DOLLAR;
      3'd1:    hdr_byte = TALKER[15:8];
      3'd2:    hdr_byte = TALKER[7:0];
      3'd3:    hdr_byte = SENT_ID[23:16];
      3'd4:    hdr_byte = SENT_ID[15:8];
      3'd5:    hdr_byte = SENT_ID[7:0];
      default: hdr_byte = CH_COMMA;
    endcase
  end

  always_comb begin
    nib = time_q[3:0];
    case (idx)
      3'd0:    nib = time_q[23:20];
      3'd1:    nib = time_q[19:16];
      3'd2:    nib = time_q[15:12];
      3'd3:    nib = time_q[11:8];
      3'd4:    nib = time_q[7:4];
      default: nib = time_q[3:0];
    endcase
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    csum_n  = csum;
    time_n  = time_q;
    fix_n   = fix_q;
    done_n  = 1'b0;
    tx_byte = 8'h00;
    in_sum  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_HDR;
          idx_n   = 3'd0;
          csum_n  = 8'h00;
          time_n  = time_bcd;
          fix_n   = fix;
        end
      end
      S_HDR: begin
        tx_byte = hdr_byte;
        in_sum  = (idx != 3'd0);  // '$' is outside the checksum
        if (xfer) begin
          if (idx == HDR_LAST) begin
            state_n = S_TIME;
            idx_n   = 3'd0;
          end else begin
            idx_n = idx + 3'd1;
          end
        end
      end
      S_TIME: begin
        tx_byte = bcd_ascii(nib);
        in_sum  = 1'b1;
        if (xfer) begin
          if (idx == TIME_LAST) begin
            state_n = S_SEP;
            idx_n   = 3'd0;
          end else begin
            idx_n = idx + 3'd1;
          end
        end
      end
      S_SEP: begin
        tx_byte = CH_COMMA;
        in_sum  = 1'b1;
        if (xfer) state_n = S_FIX;
      end
      S_FIX: begin
        tx_byte = fix_q ? 8'h31 : CH_ZERO;
        in_sum  = 1'b1;
        if (xfer) state_n = S_STAR;
      end
      S_STAR: begin
        tx_byte = CH_STAR;
        if (xfer) state_n = S_CK_HI;
      end
      S_CK_HI: begin
        tx_byte = ck_hi;
        if (xfer) state_n = S_CK_LO;
      end
      S_CK_LO: begin
        tx_byte = ck_lo;
        if (xfer) state_n = S_CR;
      end
      S_CR: begin
        tx_byte = CH_CR;
        if (xfer) state_n = S_LF;
      end
      S_LF: begin
        tx_byte = CH_LF;
        if (xfer) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (xfer && in_sum) csum_n = csum ^ tx_byte;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= S_IDLE;
      idx    <= 3'd0;
      csum   <= 8'h00;
      time_q <= 24'h0;
      fix_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      csum   <= csum_n;
      time_q <= time_n;
      fix_q  <= fix_n;
      done_q <= done_n;
    end
  end

endmodule

// File: tb/tb_nmea_sentence_tx.sv
module tb_nmea_sentence_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [23:0] time_bcd = 24'h0;
  logic        fix = 1'b0;
  logic        ready = 1'b1;
  logic [7:0]  data;
  logic        valid, busy, done;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx[$];
  logic [7:0] exp_b[20];

  nmea_sentence_tx dut (
    .CLK(clk), .RST(rst), .start(start), .time_bcd(time_bcd), .fix(fix),
    .TxD_data_out(data), .TxD_data_valid(valid), .TxD_data_ready(ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    if (obs !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, req);
    end
  endtask

  // Reference sentence built from the text format, independent of FSM structure.
  task automatic build_exp(input logic [23:0] t, input logic f);
    string hdr = "$GPGGA,";
    string hx  = "0123456789ABCDEF";
    logic [7:0] cs = 8'h00;
    logic [3:0] n;
    for (int i = 0; i < 7; i++) exp_b[i] = hdr[i];
    for (int i = 0; i < 6; i++) begin
      n = 4'(t >> (20 - 4*i));
      exp_b[7+i] = (n > 9) ? 8'h30 : 8'h30 + 8'(n);
    end
    exp_b[13] = ",";
    exp_b[14] = f ? "1" : "0";
    exp_b[15] = "*";
    for (int i = 1; i < 15; i++) cs ^= exp_b[i];
    exp_b[16] = hx[cs[7:4]];
    exp_b[17] = hx[cs[3:0]];
    exp_b[18] = 8'h0D;
    exp_b[19] = 8'h0A;
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_len"}, rx.size(), 20);
    for (int i = 0; i < 20 && i < rx.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), rx[i], exp_b[i]);
  endtask

  // Called at a negedge; start is seen at the next posedge.
  task automatic start_tx(input logic [23:0] t, input logic f);
    time_bcd = t;
    fix      = f;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Collects nb bytes. rnd toggles ready; poke_at pulses start and changes
  // time_bcd when that many bytes have gone out. Ends at a negedge.
  task automatic recv(input bit rnd, input int nb, input int poke_at,
                      input logic [23:0] poke_t, input bit at_end, output int cyc);
    logic [7:0] held = 8'h00;
    bit stalled = 0;
    cyc = 0;
    rx.delete();
    while (rx.size() < nb && cyc < 400) begin
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start = (rx.size() == poke_at);
      if (poke_at >= 0 && rx.size() >= poke_at) time_bcd = poke_t;
      #1;
      if (cyc == 0) begin
        chk("lat1_valid", valid, 1);
        chk("lat1_dollar", data, 8'h24);
      end
      if (stalled) chk("stall_hold", {valid, data}, {1'b1, held});
      if (valid && ready) begin
        rx.push_back(data);
        stalled = 0;
      end else if (valid) begin
        stalled = 1;
        held = data;
      end
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    ready = 1'b1;
    if (rx.size() < nb) chk("timeout", rx.size(), nb);
    if (at_end) begin
      #1;
      chk("done_pulse", done, 1);
      chk("busy_end", busy, 0);
      chk("valid_end", valid, 0);
    end
  endtask

  initial begin
    int cyc;
    string s1 = "$GPGGA,123519,1*6A\r\n";

    // Reset, with start asserted to show reset wins.
    start = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    #1;
    chk("post_rst_valid", valid, 0);
    @(negedge clk);

    // Reference sentence, ready held high.
    start_tx(24'h123519, 1'b1);
    build_exp(24'h123519, 1'b1);
    recv(0, 20, -1, 24'h0, 1, cyc);
    check_stream("gga_fix1");
    chk("b2b_cycles", cyc, 20);
    for (int i = 0; i < 20 && i < rx.size(); i++)
      chk($sformatf("lit_b%0d", i), rx[i], s1[i]);

    // Start in the done cycle, random ready.
    start_tx(24'h123519, 1'b0);
    build_exp(24'h123519, 1'b0);
    recv(1, 20, -1, 24'h0, 1, cyc);
    check_stream("gga_fix0");
    if (rx.size() == 20) chk("ck_6B", {rx[16], rx[17]}, 16'h3642);

    start_tx(24'h000000, 1'b0);
    build_exp(24'h000000, 1'b0);
    recv(1, 20, -1, 24'h0, 1, cyc);
    check_stream("zeros");
    if (rx.size() == 20) chk("ck_66", {rx[16], rx[17]}, 16'h3636);

    // Non-decimal nibble.
    start_tx(24'h1A3519, 1'b1);
    build_exp(24'h1A3519, 1'b1);
    recv(0, 20, -1, 24'h0, 1, cyc);
    check_stream("badbcd");
    if (rx.size() == 20) begin
      chk("digits_lo", {rx[7], rx[8], rx[9]}, 24'h313033);
      chk("digits_hi", {rx[10], rx[11], rx[12]}, 24'h353139);
      chk("ck_68", {rx[16], rx[17]}, 16'h3638);
    end

    // Start pulsed mid-sentence with new time: ignored.
    @(negedge clk);
    start_tx(24'h123519, 1'b1);
    build_exp(24'h123519, 1'b1);
    recv(0, 20, 5, 24'h999999, 1, cyc);
    check_stream("midstart");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("no_restart", valid, 0);
    end
    @(negedge clk);

    // Reset after byte 9.
    start_tx(24'h123519, 1'b1);
    recv(0, 9, -1, 24'h0, 0, cyc);
    rst = 1'b1;
    #1;
    chk("abort_valid_in", valid, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_valid", valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    @(negedge clk);
    start_tx(24'h123519, 1'b1);
    build_exp(24'h123519, 1'b1);
    recv(1, 20, -1, 24'h0, 1, cyc);
    check_stream("after_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
